// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction field positions, opcodes and bus FSM states
package cpu_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int EXT_MSB = 27;
  localparam int EXT_LSB = 24;
  localparam int RA_MSB  = 23;
  localparam int RA_LSB  = 20;
  localparam int RB_MSB  = 19;
  localparam int RB_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] LOAD = 4'h1;
  localparam logic [3:0] MOVE = 4'h2;
  localparam logic [3:0] JUMP = 4'h3;
  localparam logic [3:0] ADD  = 4'h4;
  localparam logic [3:0] SUB  = 4'h5;
  localparam logic [3:0] MUL  = 4'h6;
  localparam logic [3:0] STR  = 4'h7;
  localparam logic [3:0] PUSH = 4'h8;
  localparam logic [3:0] POP  = 4'h9;
  localparam logic [3:0] XOR  = 4'hA;
  localparam logic [3:0] HALT = 4'hB;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2,
    BUS_DONE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - registered split of a fetched word into decode fields
module instr_decoder
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [31:0] instruction,
  output logic [3:0]  opcode,
  output logic [3:0]  extra,
  output logic [3:0]  operand_a,
  output logic [3:0]  operand_b,
  output logic [15:0] immediate,
  output logic        decoded
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode    <= '0;
      extra     <= '0;
      operand_a <= '0;
      operand_b <= '0;
      immediate <= '0;
      decoded   <= 1'b0;
    end else begin
      decoded <= trigger;
      if (trigger) begin
        opcode    <= instruction[OPC_MSB:OPC_LSB];
        extra     <= instruction[EXT_MSB:EXT_LSB];
        operand_a <= instruction[RA_MSB:RA_LSB];
        operand_b <= instruction[RB_MSB:RB_LSB];
        immediate <= instruction[IMM_MSB:IMM_LSB];
      end
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - pipelined Wishbone master for fetch/load/store plus decode stage
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic [AW-1:0] i_pc,
  input  logic          i_we,
  input  logic [DW-1:0] i_value,
  input  logic          i_decode,
  output logic [DW-1:0] o_instruction,
  output logic          o_completed,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  output logic [3:0]    o_opcode,
  output logic [3:0]    o_extra,
  output logic [3:0]    o_operandA,
  output logic [3:0]    o_operandB,
  output logic [15:0]   o_immediate,
  output logic          o_decoded
);

  bus_state_t state, state_next;
  logic       dec_lat;
  logic       we_lat;
  logic       accept;
  logic       ack_now;

  assign accept  = (state == BUS_IDLE) && i_enable;
  assign ack_now = ((state == BUS_REQ) || (state == BUS_WAIT)) && i_wb_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BUS_IDLE;
    else        state <= state_next;
  end

  // An ACK in REQ completes the access even while the slave is stalling.
  always_comb begin
    state_next = state;
    case (state)
      BUS_IDLE: if (i_enable) state_next = BUS_REQ;
      BUS_REQ: begin
        if (i_wb_ack)        state_next = BUS_DONE;
        else if (!i_wb_stall) state_next = BUS_WAIT;
      end
      BUS_WAIT: if (i_wb_ack) state_next = BUS_DONE;
      BUS_DONE: state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

  // we_lat outlives o_wb_we, which clears when CYC drops, so decode can still see it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_instruction <= '0;
      o_completed   <= 1'b0;
      dec_lat       <= 1'b0;
      we_lat        <= 1'b0;
    end else begin
      o_completed <= (state == BUS_DONE);
      if (accept) begin
        o_wb_addr <= i_pc;
        o_wb_we   <= i_we;
        o_wb_data <= i_value;
        dec_lat   <= i_decode;
        we_lat    <= i_we;
        o_wb_cyc  <= 1'b1;
        o_wb_stb  <= 1'b1;
      end
      if ((state == BUS_REQ) && !i_wb_stall) o_wb_stb <= 1'b0;
      if (ack_now) begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_wb_we  <= 1'b0;
        if (!o_wb_we) o_instruction <= i_wb_data;
      end
    end
  end

  instr_decoder u_decoder (
    .clk         (clk),
    .reset       (reset),
    .trigger     (o_completed && dec_lat && !we_lat),
    .instruction (o_instruction[31:0]),
    .opcode      (o_opcode),
    .extra       (o_extra),
    .operand_a   (o_operandA),
    .operand_b   (o_operandB),
    .immediate   (o_immediate),
    .decoded     (o_decoded)
  );

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - directed and randomized bench for fetch_decode with a transaction-level model
module tb_fetch_decode;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0, i_we = 1'b0, i_decode = 1'b0;
  logic [31:0] i_pc = '0, i_value = '0, i_wb_data = '0;
  logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0;
  logic [31:0] o_instruction, o_wb_addr, o_wb_data;
  logic        o_completed, o_wb_cyc, o_wb_stb, o_wb_we, o_decoded;
  logic [3:0]  o_opcode, o_extra, o_operandA, o_operandB;
  logic [15:0] o_immediate;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_instr = '0;
  logic [3:0]  e_op = '0, e_ext = '0, e_ra = '0, e_rb = '0;
  logic [15:0] e_imm = '0;
  bit          pend_chk = 0, pend_dec = 0;

  fetch_decode #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(rst_n), .i_enable(i_enable), .i_pc(i_pc), .i_we(i_we),
    .i_value(i_value), .i_decode(i_decode), .o_instruction(o_instruction),
    .o_completed(o_completed), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .o_opcode(o_opcode), .o_extra(o_extra), .o_operandA(o_operandA),
    .o_operandB(o_operandB), .o_immediate(o_immediate), .o_decoded(o_decoded)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle after the completion pulse: decode pulse iff it was a fetch.
  task automatic check_decode();
    if (pend_dec) begin
      e_op  = 4'((exp_instr >> 28) % 16);
      e_ext = 4'((exp_instr >> 24) % 16);
      e_ra  = 4'((exp_instr >> 20) % 16);
      e_rb  = 4'((exp_instr >> 16) % 16);
      e_imm = 16'(exp_instr % 65536);
    end
    chk("decoded_pulse", o_decoded, pend_dec);
    chk("opcode", o_opcode, e_op);
    chk("extra", o_extra, e_ext);
    chk("operandA", o_operandA, e_ra);
    chk("operandB", o_operandB, e_rb);
    chk("immediate", o_immediate, e_imm);
    pend_chk = 0;
  endtask

  task automatic settle();
    step();
    if (pend_chk) check_decode();
    chk("completed_after", o_completed, 0);
  endtask

  // Launches one access (legal in idle or in the completion cycle) and runs it to
  // the completion-pulse cycle. Stall for cycles k<nstall of REQ; ACK at cycle ack_at.
  task automatic run_access(input logic [31:0] pc, input bit we, input logic [31:0] val,
                            input bit dec, input int nstall, input int ack_at,
                            input logic [31:0] rdata);
    i_pc = pc; i_we = we; i_value = val; i_decode = dec; i_enable = 1'b1;
    step();
    if (pend_chk) check_decode();
    else chk("decoded_idle", o_decoded, 0);
    for (int k = 0; k <= ack_at; k++) begin
      chk("cyc_busy", o_wb_cyc, 1);
      chk("stb", o_wb_stb, (k <= nstall) ? 32'd1 : 32'd0);
      chk("addr", o_wb_addr, pc);
      chk("we", o_wb_we, we);
      if (we) chk("wdata", o_wb_data, val);
      chk("completed_busy", o_completed, 0);
      if (k > 0) chk("decoded_busy", o_decoded, 0);
      i_wb_stall = (k < nstall);
      i_wb_ack   = (k == ack_at);
      i_wb_data  = (k == ack_at) ? rdata : $urandom;
      i_enable   = 1'($urandom_range(0, 1));
      i_pc = $urandom; i_we = 1'($urandom_range(0, 1)); i_value = $urandom;
      i_decode = 1'($urandom_range(0, 1));
      step();
    end
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_enable = 1'b1;
    if (!we) exp_instr = rdata;
    chk("cyc_done", o_wb_cyc, 0);
    chk("stb_done", o_wb_stb, 0);
    chk("we_done", o_wb_we, 0);
    chk("completed_early", o_completed, 0);
    step();
    i_enable = 1'b0;
    chk("completed", o_completed, 1);
    chk("cyc_idle", o_wb_cyc, 0);
    chk("instruction", o_instruction, exp_instr);
    chk("addr_hold", o_wb_addr, pc);
    pend_chk = 1;
    pend_dec = dec && !we;
  endtask

  initial begin
    #1;
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_instr", o_instruction, 0);
    chk("rst_completed", o_completed, 0);
    chk("rst_decoded", o_decoded, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // fetch, zero stall, ACK on first accepted cycle
    run_access(32'hB000_0000, 0, 32'h0, 1, 0, 0, 32'h1A3B_1234);
    settle();
    chk("fetch_opcode_load", o_opcode, LOAD);
    chk("fetch_imm", o_immediate, 32'h1234);

    // stalled load: STB for 4 cycles, ACK 2 cycles after acceptance
    run_access(32'h0000_0400, 0, 32'h0, 0, 3, 5, 32'hDEAD_BEEF);
    settle();

    // store, decode request ignored
    run_access(32'hB000_FFFC, 1, 32'hCAFE_BABE, 1, 0, 1, $urandom);
    settle();

    // ACK while still stalled completes the access
    run_access(32'h0000_2000, 0, 32'h0, 1, 3, 1, 32'h5432_ABCD);
    settle();

    // back-to-back fetches, second enable in the completion cycle
    run_access(32'h0000_3000, 0, 32'h0, 1, 0, 0, 32'hA123_4567);
    run_access(32'h0000_3004, 0, 32'h0, 1, 1, 3, 32'hB89A_BCDE);
    settle();

    for (int n = 0; n < 30; n++) begin
      bit we_r = 1'($urandom_range(0, 2) == 0);
      int ns = $urandom_range(0, 3);
      run_access($urandom, we_r, $urandom, 1'($urandom_range(0, 1)), ns,
                 $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 1) == 1) settle();
    end
    settle();

    // asynchronous reset while in WAIT, followed by a late ACK
    i_pc = 32'h1234_5678; i_we = 1'b1; i_value = 32'h0BAD_F00D; i_decode = 1'b0;
    i_enable = 1'b1;
    step();
    i_enable = 1'b0; i_wb_stall = 1'b0;
    step();
    chk("pre_rst_cyc", o_wb_cyc, 1);
    chk("pre_rst_stb", o_wb_stb, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc", o_wb_cyc, 0);
    chk("async_stb", o_wb_stb, 0);
    chk("async_we", o_wb_we, 0);
    chk("async_addr", o_wb_addr, 0);
    chk("async_wdata", o_wb_data, 0);
    chk("async_instr", o_instruction, 0);
    chk("async_opcode", o_opcode, 0);
    chk("async_imm", o_immediate, 0);
    step(); step();
    rst_n = 1'b1;
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_ack_completed", o_completed, 0);
      chk("late_ack_cyc", o_wb_cyc, 0);
      chk("late_ack_decoded", o_decoded, 0);
      step();
    end
    chk("late_ack_instr", o_instruction, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
